// File: rtl/apb_txn_monitor.sv
// Passive APB transaction monitor.
// Watches an APB bus, checks the setup/access handshake, and captures each
// completed transfer into a FIFO of records drained through a valid/ready port.
// Ports:
//   pclk, preset                    clock, synchronous active-high reset
//   psel..pslverr                   observed APB signals (never driven)
//   out_valid/out_ready             record handshake
//   out_addr..out_waits             head record fields
//   clr_err                         clears sticky flags and drop_count
//   err_seq, err_stable, err_onehot, err_timeout, overflow  sticky flags
//   drop_count                      records lost to a full FIFO (saturating)
module apb_txn_monitor #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NO_OF_SLAVES = 1,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned WAIT_W       = 8,
  parameter int unsigned TIMEOUT      = 0,
  localparam int unsigned STRB_W      = DATA_WIDTH / 8,
  localparam int unsigned SLV_W       = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [NO_OF_SLAVES-1:0] psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [STRB_W-1:0]       pstrb,
  input  logic [2:0]              pprot,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_write,
  output logic [STRB_W-1:0]       out_strb,
  output logic [2:0]              out_prot,
  output logic                    out_slverr,
  output logic [SLV_W-1:0]        out_slave,
  output logic [WAIT_W-1:0]       out_waits,
  input  logic                    clr_err,
  output logic                    err_seq,
  output logic                    err_stable,
  output logic                    err_onehot,
  output logic                    err_timeout,
  output logic                    overflow,
  output logic [15:0]             drop_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  write;
    logic [STRB_W-1:0]     strb;
    logic [2:0]            prot;
    logic                  slverr;
    logic [SLV_W-1:0]      slave;
    logic [WAIT_W-1:0]     waits;
  } rec_t;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                  state, state_nxt;
  logic [NO_OF_SLAVES-1:0] lat_psel, lat_psel_nxt;
  logic [ADDR_WIDTH-1:0]   lat_addr, lat_addr_nxt;
  logic                    lat_write, lat_write_nxt;
  logic [DATA_WIDTH-1:0]   lat_wdata, lat_wdata_nxt;
  logic [STRB_W-1:0]       lat_strb, lat_strb_nxt;
  logic [2:0]              lat_prot, lat_prot_nxt;
  logic [WAIT_W-1:0]       wait_cnt, wait_nxt;

  rec_t                    mem [FIFO_DEPTH];
  rec_t                    out_q, head_nxt, push_rec;
  logic [PTR_W-1:0]        rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CNT_W-1:0]        count, count_nxt, count_after_pop;
  logic                    out_valid_nxt;

  logic psel_multi, psel_ok, push, push_ok, pop, full, drop, timeout_hit;
  logic set_seq, set_stable, set_timeout;
  logic [SLV_W-1:0]        slv_idx;
  logic err_seq_nxt, err_stable_nxt, err_onehot_nxt, err_timeout_nxt, overflow_nxt;
  logic [15:0]             drop_nxt;

  // More than one select bit set: clear lowest set bit and test for leftovers.
  assign psel_multi  = (psel & (psel - NO_OF_SLAVES'(1))) != '0;
  assign psel_ok     = (psel != '0) && !psel_multi;
  assign timeout_hit = (TIMEOUT != 0) && ((64'(wait_cnt) + 64'd1) >= 64'(TIMEOUT));

  // Binary index of the latched (one-hot) select.
  always_comb begin
    slv_idx = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (lat_psel[i]) slv_idx = SLV_W'(i);
    end
  end

  always_comb begin
    push_rec.addr   = lat_addr;
    push_rec.data   = lat_write ? lat_wdata : prdata;
    push_rec.write  = lat_write;
    push_rec.strb   = lat_strb;
    push_rec.prot   = lat_prot;
    push_rec.slverr = pslverr;
    push_rec.slave  = slv_idx;
    push_rec.waits  = wait_cnt;
  end

  // Protocol FSM: next state, setup latch, wait counter, error/push strobes.
  always_comb begin
    state_nxt     = state;
    lat_psel_nxt  = lat_psel;
    lat_addr_nxt  = lat_addr;
    lat_write_nxt = lat_write;
    lat_wdata_nxt = lat_wdata;
    lat_strb_nxt  = lat_strb;
    lat_prot_nxt  = lat_prot;
    wait_nxt      = wait_cnt;
    set_seq       = 1'b0;
    set_stable    = 1'b0;
    set_timeout   = 1'b0;
    push          = 1'b0;
    case (state)
      S_IDLE: begin
        if (psel_ok) begin
          if (!penable) begin
            lat_psel_nxt  = psel;
            lat_addr_nxt  = paddr;
            lat_write_nxt = pwrite;
            lat_wdata_nxt = pwdata;
            lat_strb_nxt  = pstrb;
            lat_prot_nxt  = pprot;
            wait_nxt      = '0;
            state_nxt     = S_ACCESS;
          end else begin
            set_seq = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (!psel_ok || (psel != lat_psel) || !penable) begin
          set_seq   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          set_stable = (paddr != lat_addr) || (pwrite != lat_write) ||
                       (pstrb != lat_strb) || (pprot != lat_prot) ||
                       (lat_write && (pwdata != lat_wdata));
          if (pready) begin
            push      = 1'b1;
            state_nxt = S_IDLE;
          end else if (timeout_hit) begin
            set_timeout = 1'b1;
            state_nxt   = S_IDLE;
          end else if (wait_cnt != '1) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; out_q is a registered copy of the post-update head.
  always_comb begin
    full            = count == CNT_W'(FIFO_DEPTH);
    pop             = out_valid && out_ready;
    push_ok         = push && (!full || pop);
    drop            = push && full && !pop;
    count_after_pop = count - CNT_W'(pop);
    count_nxt       = count_after_pop + CNT_W'(push_ok);
    rd_nxt          = rd_ptr + PTR_W'(pop);
    wr_nxt          = wr_ptr + PTR_W'(push_ok);
    out_valid_nxt   = count_nxt != '0;
    if (count_nxt == '0)            head_nxt = '0;
    else if (count_after_pop == '0) head_nxt = push_rec;
    else                            head_nxt = mem[rd_nxt];
  end

  // Sticky flags: a new event wins over a simultaneous clear.
  always_comb begin
    err_seq_nxt     = set_seq     | (err_seq     & ~clr_err);
    err_stable_nxt  = set_stable  | (err_stable  & ~clr_err);
    err_onehot_nxt  = psel_multi  | (err_onehot  & ~clr_err);
    err_timeout_nxt = set_timeout | (err_timeout & ~clr_err);
    overflow_nxt    = drop        | (overflow    & ~clr_err);
    if (clr_err)                            drop_nxt = 16'(drop);
    else if (drop && drop_count != 16'hFFFF) drop_nxt = drop_count + 16'd1;
    else                                    drop_nxt = drop_count;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= S_IDLE;
      lat_psel    <= '0;
      lat_addr    <= '0;
      lat_write   <= 1'b0;
      lat_wdata   <= '0;
      lat_strb    <= '0;
      lat_prot    <= '0;
      wait_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_q       <= '0;
      err_seq     <= 1'b0;
      err_stable  <= 1'b0;
      err_onehot  <= 1'b0;
      err_timeout <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      state       <= state_nxt;
      lat_psel    <= lat_psel_nxt;
      lat_addr    <= lat_addr_nxt;
      lat_write   <= lat_write_nxt;
      lat_wdata   <= lat_wdata_nxt;
      lat_strb    <= lat_strb_nxt;
      lat_prot    <= lat_prot_nxt;
      wait_cnt    <= wait_nxt;
      rd_ptr      <= rd_nxt;
      wr_ptr      <= wr_nxt;
      count       <= count_nxt;
      out_valid   <= out_valid_nxt;
      out_q       <= head_nxt;
      err_seq     <= err_seq_nxt;
      err_stable  <= err_stable_nxt;
      err_onehot  <= err_onehot_nxt;
      err_timeout <= err_timeout_nxt;
      overflow    <= overflow_nxt;
      drop_count  <= drop_nxt;
    end
  end

  // Record storage needs no reset; pointers define what is valid.
  always_ff @(posedge pclk) begin
    if (!preset && push_ok) mem[wr_ptr] <= push_rec;
  end

  assign out_addr   = out_q.addr;
  assign out_data   = out_q.data;
  assign out_write  = out_q.write;
  assign out_strb   = out_q.strb;
  assign out_prot   = out_q.prot;
  assign out_slverr = out_q.slverr;
  assign out_slave  = out_q.slave;
  assign out_waits  = out_q.waits;

endmodule

// File: doc/apb_txn_monitor.md
APB_TXN_MONITOR -- requirements
Module: apb_txn_monitor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of paddr and out_addr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32 (8/16/32 legal), width of pwdata/prdata/out_data; pstrb width DATA_WIDTH/8.
REQ-003 SHALL have parameter NO_OF_SLAVES, default 1 (1-16), width of psel.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8 (power of 2, >=2), capture FIFO entries.
REQ-005 SHALL have parameter WAIT_W, default 8, width of the wait-state count field.
REQ-006 SHALL have parameter TIMEOUT, default 0, max wait states before abort; 0 disables.
REQ-007 SHALL have ports: pclk in 1 APB clock; preset in 1 synchronous active-high reset; one clock, reset sampled only on rising pclk.
REQ-008 SHALL have monitor inputs, all observed only: psel in NO_OF_SLAVES; penable in 1; pwrite in 1; paddr in ADDR_WIDTH; pwdata in DATA_WIDTH; pstrb in DATA_WIDTH/8; pprot in 3; pready in 1; prdata in DATA_WIDTH; pslverr in 1.
REQ-009 SHALL have ports: out_valid out 1 record available; out_ready in 1 consumer accept; out_addr out ADDR_WIDTH; out_data out DATA_WIDTH (pwdata if write, prdata if read); out_write out 1; out_strb out DATA_WIDTH/8; out_prot out 3; out_slverr out 1; out_slave out clog2(NO_OF_SLAVES) min 1, index of asserted psel; out_waits out WAIT_W.
REQ-010 SHALL have ports: clr_err in 1 clears sticky errors; err_seq, err_stable, err_onehot, err_timeout, overflow out 1 each, sticky; drop_count out 16 dropped records.

Function
REQ-011 SHALL run FSM with states IDLE (expecting setup) and ACCESS (expecting access phase), evaluated every rising pclk.
REQ-012 IDLE: psel!=0 and penable=0 -> latch paddr/pwrite/pwdata/pstrb/pprot/psel, clear wait counter, go ACCESS; psel!=0 and penable=1 -> set err_seq, stay IDLE; psel=0 -> stay IDLE.
REQ-013 ACCESS: psel!=latched psel or penable=0 -> set err_seq, discard transfer, go IDLE (no record).
REQ-014 ACCESS with pready=0: wait counter +1, saturating at all-ones; stay ACCESS.
REQ-015 ACCESS with pready=1: complete; push record (latched setup fields, prdata for reads, pslverr, wait counter) into FIFO at that same edge; go IDLE.
REQ-016 ACCESS, any cycle: paddr/pwrite/pstrb/pprot, or pwdata when write, differing from latched value -> set err_stable; transfer still completes with latched values.
REQ-017 Any cycle with more than one psel bit set -> set err_onehot; that cycle is treated as psel=0 in IDLE and as a sequence error (REQ-013) in ACCESS.
REQ-018 TIMEOUT!=0 and wait counter reaching TIMEOUT with pready=0 -> set err_timeout, discard, go IDLE.
REQ-019 Back-to-back transfers: setup in the cycle after a completion is accepted (IDLE evaluated that cycle); zero idle cycles required.
REQ-020 Latency: record visible on out_* with out_valid=1 the cycle after completion edge when FIFO was empty; out_* stable while out_valid=1 and out_ready=0.
REQ-021 Pop on out_valid&&out_ready; FIFO order strictly first-in first-out.
REQ-022 Push when full and no pop that cycle -> record dropped, overflow set, drop_count +1 saturating at 16'hFFFF.
REQ-023 Push and pop same cycle when full -> both performed, no drop; same cycle when empty -> push stored, out_valid rises next cycle.
REQ-024 Error flags stay set until clr_err=1; clr_err same cycle as a new error -> flag remains set; clr_err also zeroes drop_count and overflow.
REQ-025 out_slave for NO_OF_SLAVES=1 SHALL be 0.

Reset
REQ-026 preset=1 at rising pclk: FSM IDLE, FIFO emptied, out_valid=0, all error flags/overflow 0, drop_count 0, out_* data fields 0.
REQ-027 Reset mid-ACCESS abandons the transfer with no record and no error; monitoring resumes the first cycle with preset=0.

Verification
REQ-028 Write paddr=0x10, pwdata=0xA5A5_0001, pstrb=0xF, 0 waits, out_ready=1 -> one record addr 0x10, data 0xA5A5_0001, write 1, waits 0, one cycle after completion.
REQ-029 Read paddr=0x24, 3 waits, prdata=0xDEAD_BEEF, pslverr=1 -> record data 0xDEAD_BEEF, write 0, waits 3, slverr 1.
REQ-030 out_ready=0, 9 back-to-back transfers, FIFO_DEPTH=8 -> 8 records retained in order, overflow=1, drop_count=1.
REQ-031 penable=1 in first psel cycle -> err_seq=1, no record; paddr change during wait -> err_stable=1, record keeps original address.
REQ-032 TIMEOUT=4, pready held 0 -> err_timeout=1 after 4th wait, FSM IDLE, no record; psel=2'b11 -> err_onehot=1; clr_err -> all flags 0.
REQ-033 preset asserted during a waiting read -> no record, all outputs at reset values, next transfer captured normally.
